spi_ram: RTL
============

Name: spi_ram

Overview:
- Single-port synchronous memory that sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit rx_data/rx_valid command words and returns read data on tx_data/tx_valid, which feed the slave's serializer.
- Two command bits select write-address, write-data, read-address or read-data; the low 8 bits carry the address or data payload.
- Together with the SPI slave it forms the SPI-to-RAM wrapper.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words; must equal 2**ADDR_SIZE.
- ADDR_SIZE, 8, width of the address registers and of the payload field used as an address.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
- din  input  10  command word from the SPI slave; din[9:8] = opcode, din[7:0] = payload.
- rx_valid  input  1  din is valid this cycle; one command is executed per cycle in which it is high.
- dout  output  8  read data returned toward the SPI slave (the slave's tx_data).
- tx_valid  output  1  dout holds fresh read data; single-cycle pulse.

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - dout=8'h00, tx_valid=0.
  - Internal wr_addr=0, rd_addr=0.
  - Memory array contents are NOT cleared.
  - Reset has priority over any rx_valid command in the same cycle.
- Commands are decoded only when rx_valid=1 and rst_n=1. No command executes while rx_valid=0.
- Opcode 2'b00, write address: wr_addr <= din[7:0]. No memory access, tx_valid=0.
- Opcode 2'b01, write data: mem[wr_addr] <= din[7:0]. wr_addr is unchanged, so repeated 01 commands overwrite the same location.
- Opcode 2'b10, read address: rd_addr <= din[7:0]. No memory access, tx_valid=0.
- Opcode 2'b11, read data:
  - dout <= mem[rd_addr] on the same edge, and tx_valid <= 1 on the same edge.
  - Read latency is 1 cycle from the rx_valid edge; rd_addr is unchanged.
- tx_valid is a one-cycle pulse. It returns to 0 on the next edge unless another 11 command is accepted on that edge; back-to-back 11 commands hold tx_valid high for consecutive cycles.
- dout holds its last read value until the next read-data command or reset. It is never driven by write commands.
- wr_addr and rd_addr are independent registers. A write-address command never changes rd_addr, and vice versa.
- Out-of-order use:
  - Write-data with no prior write-address writes to wr_addr (0 after reset).
  - Read-data with no prior read-address reads rd_addr (0 after reset).
  - Neither case is an error.
- Read-after-write: a write-data command at cycle N followed by read-data of the same address at cycle N+1 returns the new data. The write completes on edge N.
- rx_valid held high for several cycles: each cycle is a separate command using the current din. Duplicate writes are idempotent; duplicate reads produce repeated tx_valid pulses.
- Address wrap: the payload is 8 bits and MEM_DEPTH=256, so every address is in range. No masking or bounds error exists.
- Reset asserted the cycle after a read-data command: tx_valid is forced to 0 and dout to 0 on that edge. The pending read is discarded.
- Memory is inferred as a plain 8-bit register array with synchronous write and registered read. There are no byte enables and no X-propagation on uninitialised reads beyond simulator default.

Test Plan:
- Reset: rst_n=0 for 2 cycles with rx_valid=1, din=10'h3FF -> dout=0 and tx_valid=0 throughout. After release, read-data returns the value stored before reset (contents preserved).
- Basic write/read: 00+8'h2A, 01+8'hC3, 10+8'h2A, 11+8'h00, one per cycle -> tx_valid=1 exactly one cycle after the 11 command, dout=8'hC3, then tx_valid=0.
- Address independence: 00+8'h10, 10+8'h20, 01+8'h55, 11 -> dout = mem[0x20] (unchanged by the write); a separate read of 0x10 -> 8'h55.
- Back-to-back and boundary: write 8'hFF to 8'hFF and 8'h01 to 8'h00, then 10+8'hFF and two consecutive 11 cycles -> tx_valid high for 2 cycles, dout=8'hFF. Repeat at 8'h00 -> dout=8'h01.
- Read-after-write: 10+8'h05, then 00+8'h05, 01+8'hA5, 11 on consecutive cycles -> dout=8'hA5 one cycle after the 11.
- Reset mid-read: 11 command at cycle N, rst_n=0 at cycle N+1 -> tx_valid=0 and dout=0 after edge N+1. The next read-data after reset uses rd_addr=0.

Source files
------------

// File: rtl/spi_ram.sv
// Command-driven 256x8 RAM sitting behind the SPI slave: decodes 10-bit
// command words into address/data writes and registered reads toward tx_data.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_t;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  op_t                  op;
  logic [7:0]           payload;
  logic                 wr_addr_en;
  logic                 rd_addr_en;
  logic                 wr_en;
  logic                 rd_en;

  always_comb begin
    op         = op_t'(din[9:8]);
    payload    = din[7:0];
    wr_addr_en = rx_valid && (op == OP_WR_ADDR);
    rd_addr_en = rx_valid && (op == OP_RD_ADDR);
    // Reset blocks the memory write so a reset cycle never corrupts contents.
    wr_en      = rst_n && rx_valid && (op == OP_WR_DATA);
    rd_en      = rx_valid && (op == OP_RD_DATA);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= rd_en;
      if (wr_addr_en) wr_addr <= payload[ADDR_SIZE-1:0];
      if (rd_addr_en) rd_addr <= payload[ADDR_SIZE-1:0];
      if (rd_en)      dout    <= mem[rd_addr];
    end
  end

  // Storage is deliberately left out of reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= payload;
  end

endmodule
